// File: rtl/complex_counter.sv
// 3-bit counter stepping in binary or reflected Gray order, mode chosen per edge by M.
// Count is a plain register; the successor is always computed from its present value.
module complex_counter (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       M,
   output logic [2:0] Count
);

   logic [2:0] count_q;
   logic [2:0] count_d;
   logic [2:0] bin_next;
   logic [2:0] gray_next;

   assign bin_next = count_q + 3'd1;

   // Full 8-entry table so every state has a successor; no lockup is possible.
   always_comb begin
      gray_next = 3'b000;
      unique case (count_q)
         3'b000:  gray_next = 3'b001;
         3'b001:  gray_next = 3'b011;
         3'b011:  gray_next = 3'b010;
         3'b010:  gray_next = 3'b110;
         3'b110:  gray_next = 3'b111;
         3'b111:  gray_next = 3'b101;
         3'b101:  gray_next = 3'b100;
         3'b100:  gray_next = 3'b000;
         default: gray_next = 3'b000;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (nReset) begin
         count_d = 3'b000;
      end else if (M) begin
         count_d = gray_next;
      end else begin
         count_d = bin_next;
      end
   end

   // The nReset port is active high despite its name.
   always_ff @(posedge Clk) begin
      count_q <= count_d;
   end

   assign Count = count_q;

endmodule

// File: tb/tb_complex_counter.sv
// Self-checking bench for complex_counter: vector table plus model-driven sequences,
// expected values queued at drive time and compared one clock later.
module tb_complex_counter;

   logic       Clk;
   logic       nReset;
   logic       M;
   logic [2:0] Count;

   typedef struct {
      logic       rst;
      logic       m;
      logic [2:0] exp;
      logic       chk1;
   } vec_t;

   vec_t       vecs[$];
   logic [2:0] sb_q[$];
   int         total;
   int         bad;
   logic [2:0] model;
   logic [2:0] prev;

   complex_counter dut (
      .Clk   (Clk),
      .nReset(nReset),
      .M     (M),
      .Count (Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] gray_succ(input logic [2:0] g);
      logic [2:0] b;
      b[2] = g[2];
      b[1] = g[2] ^ g[1];
      b[0] = g[2] ^ g[1] ^ g[0];
      b = b + 3'd1;
      return b ^ (b >> 1);
   endfunction

   function automatic logic [2:0] model_next(input logic [2:0] c, input logic rst, input logic m);
      if (rst) return 3'b000;
      if (m) return gray_succ(c);
      return c + 3'd1;
   endfunction

   task automatic add(input logic rst, input logic m, input logic [2:0] exp, input logic chk1);
      vec_t v;
      v.rst = rst; v.m = m; v.exp = exp; v.chk1 = chk1;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic m, input logic [2:0] exp,
                        input logic chk1, input string name);
      logic [2:0] e;
      @(negedge Clk);
      prev   = Count;
      nReset = rst;
      M      = m;
      sb_q.push_back(exp);
      @(posedge Clk);
      #1;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, actual=%b", name, Count);
      end else begin
         e = sb_q.pop_front();
         if (Count !== e) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b (rst=%b m=%b prev=%b)",
                     name, Count, e, rst, m, prev);
         end
      end
      if (chk1) begin
         total++;
         if ($countones(prev ^ Count) != 1) begin
            bad++;
            $display("FAIL %s_onebit: actual=%b prev=%b required one bit change",
                     name, Count, prev);
         end
      end
      model = exp;
   endtask

   initial begin
      logic [2:0] bin_seq[8];
      logic [2:0] gray_seq[8];
      logic [2:0] e;
      logic       r;
      logic       mm;
      total = 0;
      bad   = 0;
      nReset = 1'b1;
      M      = 1'b0;
      model  = 3'b000;
      bin_seq  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

      // reset held two clocks
      add(1, 0, 3'b000, 0);
      add(1, 0, 3'b000, 0);
      // binary run of 20 clocks from 000
      for (int i = 1; i <= 20; i++) add(0, 0, bin_seq[i % 8], 0);
      // Count is 100 here; switch to Gray without reset: 100 -> 000 -> 001 ...
      for (int i = 0; i < 20; i++) add(0, 1, gray_seq[i % 8], 1);
      // mid-Gray reset, release in binary
      add(1, 1, 3'b000, 0);
      add(1, 1, 3'b000, 0);
      add(0, 0, 3'b001, 0);
      add(0, 0, 3'b010, 0);
      add(0, 0, 3'b011, 0);
      // reset then full Gray lap
      add(1, 0, 3'b000, 0);
      add(1, 0, 3'b000, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, gray_seq[i % 8], 1);
      // mode switch example: binary to 011, then Gray step to 010
      add(1, 0, 3'b000, 0);
      add(0, 0, 3'b001, 0);
      add(0, 0, 3'b010, 0);
      add(0, 0, 3'b011, 0);
      add(0, 1, 3'b010, 1);

      foreach (vecs[i]) drive(vecs[i].rst, vecs[i].m, vecs[i].exp, vecs[i].chk1, "vec");

      // toggle M every clock from 000, first edge with M=1
      drive(1, 0, 3'b000, 0, "tog_rst");
      mm = 1'b1;
      for (int i = 0; i < 24; i++) begin
         e = model_next(model, 1'b0, mm);
         drive(0, mm, e, mm, "toggle");
         mm = ~mm;
      end

      // random mode and occasional reset against the model
      for (int i = 0; i < 60; i++) begin
         r  = ($urandom_range(0, 9) == 0);
         mm = $urandom_range(0, 1);
         e  = model_next(model, r, mm);
         drive(r, mm, e, 1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/complex_counter.md
COMPLEX_COUNTER -- requirements
Module: complex_counter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: reset is sampled only on the rising clock edge and is asserted when the reset port is 1.
REQ-002 Port list (clock and reset first):
- Clk     input   1  system clock; all state updates on its rising edge.
- nReset  input   1  synchronous active-high reset; 1 = reset asserted, 0 = normal counting (the port name is retained for codebase compatibility; polarity is as stated here).
- M       input   1  mode select; 0 = binary up-count, 1 = Gray-code up-count.
- Count   output  3  current counter state, driven directly from a register.
REQ-003 The block SHALL have no parameters; the counter width is fixed at 3 bits.

Function
REQ-004 Count SHALL change only on a rising edge of Clk; there is no combinational path from M or nReset to Count.
REQ-005 Reset asserted at a rising edge SHALL load Count = 3'b000, regardless of M.
REQ-006 Reset SHALL take priority over counting: no increment occurs on any edge where reset is asserted.
REQ-007 With reset deasserted and M = 0 at a rising edge, the next Count SHALL be (Count + 1) mod 8: 000, 001, 010, 011, 100, 101, 110, 111, 000.
REQ-008 With reset deasserted and M = 1 at a rising edge, the next Count SHALL be the Gray successor of the current Count, per this table:
- 000 -> 001
- 001 -> 011
- 011 -> 010
- 010 -> 110
- 110 -> 111
- 111 -> 101
- 101 -> 100
- 100 -> 000
REQ-009 In Gray mode, exactly one bit of Count SHALL change per clock, including at the wrap 100 -> 000.
REQ-010 The next-state function SHALL be defined for all 8 Count values in both modes; there are no illegal states and no lockup.
REQ-011 A change of M SHALL take effect on the next rising edge: the successor is computed from the present Count using the mode sampled at that edge, with no reset or re-sync.
- Example: Count = 011, M switches 0 -> 1, next Count = 010.
REQ-012 Latency SHALL be one clock from a sampled M or reset value to the corresponding Count update.
REQ-013 Both sequences SHALL wrap with a period of 8 clocks; there is no terminal-count output and no hold or stop state.
REQ-014 Count SHALL be X-free from the first rising edge at which reset is asserted.

Reset
REQ-015 On deassertion of reset, the first non-reset rising edge SHALL advance Count from 000 to 001 in either mode.
REQ-016 Reset asserted mid-sequence, in either mode, SHALL force Count = 000 at the next rising edge, discarding the previous state.
REQ-017 Holding reset for multiple cycles SHALL hold Count at 000.
REQ-018 Count before the first reset edge is undefined; benches SHALL apply reset for at least one clock before checking.

Verification
REQ-019 Hold reset = 1 for 2 clocks with M = 0 -> Count = 000 after the first edge, then stays 000.
REQ-020 Release reset with M = 0 and run 20 clocks -> Count steps 001, 010, ..., 111, 000, 001, ... with a wrap every 8 clocks.
REQ-021 From free-running binary count, set M = 1 without reset -> each following Count is the Gray successor of the prior value; check a single-bit change per clock for 20 clocks.
REQ-022 Assert reset for 2 clocks mid-Gray-sequence, then release with M = 0 -> Count = 000, then 001, 010, 011, ...
REQ-023 Assert reset for 2 clocks, then release with M = 1 -> Count = 000, 001, 011, 010, 110, 111, 101, 100, 000.
REQ-024 Toggle M every clock starting from 000 -> the sequence follows REQ-011 per edge (M = 1: 000 -> 001; M = 0: 001 -> 010; M = 1: 010 -> 110; ...); a scoreboard model compares Count every cycle.
